// File: rtl/lockin_pkg.sv
// Shared definitions for the lock-in demodulator: FSM states, default widths, saturation limits.
package lockin_pkg;

  localparam int unsigned DEF_CH    = 2;
  localparam int unsigned DEF_DW    = 16;
  localparam int unsigned DEF_RW    = 16;
  localparam int unsigned DEF_NW    = 16;
  localparam int unsigned DEF_ACCW  = 48;
  localparam int unsigned DEF_SHIFT = 17;

  localparam logic [DEF_DW-1:0] SAT_MAX = {1'b0, {(DEF_DW-1){1'b1}}};
  localparam logic [DEF_DW-1:0] SAT_MIN = {1'b1, {(DEF_DW-1){1'b0}}};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/lockin_mac.sv
// One channel/path of the lock-in: registered product, boxcar accumulate, dump with scaling.
// LOCKIN_OUT_SAT_EN selects clamping of the scaled result instead of plain truncation.
module lockin_mac
  import lockin_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned RW    = DEF_RW,
  parameter int unsigned ACCW  = DEF_ACCW,
  parameter int unsigned SHIFT = DEF_SHIFT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 accept,
  input  logic                 flush,
  input  logic                 step,
  input  logic                 last,
  input  logic signed [DW-1:0] a,
  input  logic signed [RW-1:0] b,
  output logic        [DW-1:0] res,
  output logic                 sat_c
);

  localparam int unsigned PW = DW + RW;

  logic signed [PW-1:0]   prod_q;
  logic signed [ACCW-1:0] acc_q;
  logic signed [ACCW-1:0] sum_c;
  logic        [DW-1:0]   scaled_c;

  assign sum_c = acc_q + ACCW'(prod_q);

  // Scale the window total; optionally clamp when the upper bits are not a pure sign extension.
  always_comb begin
    scaled_c = sum_c[SHIFT +: DW];
    sat_c    = 1'b0;
`ifdef LOCKIN_OUT_SAT_EN
    if (!((&sum_c[ACCW-1:SHIFT+DW-1]) || !(|sum_c[ACCW-1:SHIFT+DW-1]))) begin
      sat_c    = 1'b1;
      scaled_c = sum_c[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q <= '0;
      acc_q  <= '0;
      res    <= '0;
    end else if (flush) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      if (accept) prod_q <= PW'(a) * PW'(b);
      if (step) begin
        acc_q <= last ? '0 : sum_c;
        if (last) res <= scaled_c;
      end
    end
  end

endmodule

// File: rtl/lockin_demod.sv
// Multi-channel I/Q lock-in demodulator: shared window control around 2*CH MAC lanes.
// Build with LOCKIN_OUT_SAT_EN to saturate results and report ovf.
module lockin_demod
  import lockin_pkg::*;
#(
  parameter int unsigned CH    = DEF_CH,
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned RW    = DEF_RW,
  parameter int unsigned NW    = DEF_NW,
  parameter int unsigned ACCW  = DEF_ACCW,
  parameter int unsigned SHIFT = DEF_SHIFT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [NW-1:0]    window_len,
  input  logic             sample_valid,
  input  logic [CH*DW-1:0] sample,
  input  logic [RW-1:0]    ref_cos,
  input  logic [RW-1:0]    ref_sin,
  output logic             out_valid,
  output logic [CH*DW-1:0] out_i,
  output logic [CH*DW-1:0] out_q,
  output logic             busy,
  output logic             ovf
);

  if (ACCW < DW + RW + NW) begin : g_accw_chk
    $error("lockin_demod: ACCW must be at least DW+RW+NW");
  end

  state_t        state_q;
  logic [NW-1:0] len_q;
  logic [NW-1:0] cnt_q;
  logic          s1_valid_q;
  logic          s1_last_q;
  logic [NW-1:0] len_next_c;
  logic          last_c;
  logic          accept_c;
  logic          flush_c;
  logic          dump_c;
  logic [2*CH-1:0] sat_c;

  assign len_next_c = (window_len == '0) ? NW'(1) : window_len;
  assign last_c     = (cnt_q == len_q - NW'(1));
  assign accept_c   = (state_q == RUN) && enable && sample_valid;
  // Anything not running (or stopping this edge) discards partial sums and in-flight products.
  assign flush_c    = (state_q != RUN) || !enable;
  assign dump_c     = s1_valid_q && s1_last_q && !flush_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      busy       <= 1'b0;
      len_q      <= NW'(1);
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      out_valid  <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      s1_valid_q <= accept_c;
      s1_last_q  <= accept_c && last_c;
      out_valid  <= dump_c;
      if (dump_c && (|sat_c)) ovf <= 1'b1;
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q <= RUN;
            busy    <= 1'b1;
            len_q   <= len_next_c;
            cnt_q   <= '0;
            ovf     <= 1'b0;
          end
        end
        RUN: begin
          if (!enable) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            cnt_q   <= '0;
          end else if (sample_valid) begin
            if (last_c) begin
              cnt_q <= '0;
              len_q <= len_next_c;
            end else begin
              cnt_q <= cnt_q + NW'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    lockin_mac #(.DW(DW), .RW(RW), .ACCW(ACCW), .SHIFT(SHIFT)) u_mac_i (
      .clk    (clk),
      .rst    (rst),
      .accept (accept_c),
      .flush  (flush_c),
      .step   (s1_valid_q),
      .last   (s1_last_q),
      .a      (sample[k*DW +: DW]),
      .b      (ref_cos),
      .res    (out_i[k*DW +: DW]),
      .sat_c  (sat_c[2*k])
    );
    lockin_mac #(.DW(DW), .RW(RW), .ACCW(ACCW), .SHIFT(SHIFT)) u_mac_q (
      .clk    (clk),
      .rst    (rst),
      .accept (accept_c),
      .flush  (flush_c),
      .step   (s1_valid_q),
      .last   (s1_last_q),
      .a      (sample[k*DW +: DW]),
      .b      (ref_sin),
      .res    (out_q[k*DW +: DW]),
      .sat_c  (sat_c[2*k+1])
    );
  end

endmodule

// File: tb/tb_lockin_demod.sv
// Self-checking bench for lockin_demod: window-level sum model plus directed and random stimulus.
module tb_lockin_demod;

  localparam int CH = 2;
  localparam int DW = 16;
  localparam int RW = 16;
  localparam int NW = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [NW-1:0]    window_len;
  logic             sample_valid;
  logic [CH*DW-1:0] sample;
  logic [RW-1:0]    ref_cos;
  logic [RW-1:0]    ref_sin;
  logic             out_valid;
  logic [CH*DW-1:0] out_i;
  logic [CH*DW-1:0] out_q;
  logic             busy;
  logic             ovf;

  always #5 clk = ~clk;

  lockin_demod dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .window_len   (window_len),
    .sample_valid (sample_valid),
    .sample       (sample),
    .ref_cos      (ref_cos),
    .ref_sin      (ref_sin),
    .out_valid    (out_valid),
    .out_i        (out_i),
    .out_q        (out_q),
    .busy         (busy),
    .ovf          (ovf)
  );

  int checks;
  int failures;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: per-window running sums of exact products, results due one edge after the final sample's edge.
  typedef struct {
    int     due;
    longint si0, si1, sq0, sq1;
  } res_t;

  res_t        pend[$];
  bit          m_run;
  int          m_len, m_cnt, t;
  longint      si0, si1, sq0, sq1;
  logic [15:0] e_i0, e_i1, e_q0, e_q1;
  bit          e_ovf;

  function automatic int eff_len(input logic [NW-1:0] l);
    return (l == 0) ? 1 : int'(l);
  endfunction

  function automatic logic [15:0] scale(input longint s, output bit sat);
    longint sh;
    sh  = s >>> 17;
    sat = 1'b0;
`ifdef LOCKIN_OUT_SAT_EN
    if (sh > 32767) begin sat = 1'b1; return 16'h7FFF; end
    if (sh < -32768) begin sat = 1'b1; return 16'h8000; end
`endif
    return sh[15:0];
  endfunction

  task automatic model_reset();
    m_run = 0; m_len = 1; m_cnt = 0;
    si0 = 0; si1 = 0; sq0 = 0; sq1 = 0;
    e_i0 = 0; e_i1 = 0; e_q0 = 0; e_q1 = 0; e_ovf = 0;
    pend.delete();
  endtask

  // One clock: apply inputs, advance the model, take the edge, compare.
  task automatic cyc(input bit en, input bit v, input logic [15:0] a0, input logic [15:0] a1,
                     input logic [15:0] c, input logic [15:0] s);
    bit   exp_v, st;
    res_t r;
    enable = en; sample_valid = v; sample = {a1, a0}; ref_cos = c; ref_sin = s;
    if (m_run && !en) begin
      m_run = 0; m_cnt = 0;
      si0 = 0; si1 = 0; sq0 = 0; sq1 = 0;
      if (pend.size() > 0 && pend[0].due == t) void'(pend.pop_front());
    end else if (!m_run && en) begin
      m_run = 1; m_cnt = 0; m_len = eff_len(window_len); e_ovf = 0;
      si0 = 0; si1 = 0; sq0 = 0; sq1 = 0;
    end else if (m_run && v) begin
      si0 += longint'($signed(a0)) * longint'($signed(c));
      si1 += longint'($signed(a1)) * longint'($signed(c));
      sq0 += longint'($signed(a0)) * longint'($signed(s));
      sq1 += longint'($signed(a1)) * longint'($signed(s));
      m_cnt++;
      if (m_cnt == m_len) begin
        r.due = t + 1; r.si0 = si0; r.si1 = si1; r.sq0 = sq0; r.sq1 = sq1;
        pend.push_back(r);
        si0 = 0; si1 = 0; sq0 = 0; sq1 = 0;
        m_cnt = 0; m_len = eff_len(window_len);
      end
    end
    @(posedge clk);
    #1;
    exp_v = 0;
    if (pend.size() > 0 && pend[0].due == t) begin
      r = pend.pop_front();
      exp_v = 1;
      e_i0 = scale(r.si0, st); e_ovf |= st;
      e_i1 = scale(r.si1, st); e_ovf |= st;
      e_q0 = scale(r.sq0, st); e_ovf |= st;
      e_q1 = scale(r.sq1, st); e_ovf |= st;
    end
    check("out_valid", 64'(out_valid), 64'(exp_v));
    check("busy", 64'(busy), 64'(m_run));
    check("out_i", 64'(out_i), 64'({e_i1, e_i0}));
    check("out_q", 64'(out_q), 64'({e_q1, e_q0}));
    check("ovf", 64'(ovf), 64'(e_ovf));
    t++;
  endtask

  task automatic run_const(input int n, input int period, input logic [15:0] a);
    for (int i = 0; i < n; i++) cyc(1, (i % period) == period - 1, a, a, 16'h7FFF, 16'h0000);
  endtask

  task automatic restart(input logic [NW-1:0] len);
    cyc(0, 0, 0, 0, 0, 0);
    window_len = len;
    cyc(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    checks = 0; failures = 0; t = 0;
    rst = 1'b0; enable = 0; sample_valid = 0; window_len = 0;
    sample = 0; ref_cos = 0; ref_sin = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_i", 64'(out_i), 64'd0);
    check("rst_out_q", 64'(out_q), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b1;

    // Window 4, continuous.
    restart(16'd4);
    run_const(14, 1, 16'h4000);
    check("w4_i", 64'(out_i), 64'h3FFF_3FFF);
    check("w4_q", 64'(out_q), 64'd0);

    // Window 16: exceeds the output range.
    restart(16'd16);
    run_const(18, 1, 16'h4000);
`ifdef LOCKIN_OUT_SAT_EN
    check("w16_i", 64'(out_i), 64'h7FFF_7FFF);
    check("w16_ovf", 64'(ovf), 64'd1);
`else
    check("w16_i", 64'(out_i), 64'hFFFE_FFFE);
    check("w16_ovf", 64'(ovf), 64'd0);
`endif

    // Window 4, one sample every third cycle.
    restart(16'd4);
    run_const(14, 3, 16'h4000);
    check("gap_i", 64'(out_i), 64'h3FFF_3FFF);

    // Window length 0 behaves as 1.
    restart(16'd0);
    run_const(6, 1, 16'h4000);
    check("w0_i", 64'(out_i), 64'h0FFF_0FFF);

    // Abort after two samples; idle samples ignored; clean restart.
    restart(16'd4);
    run_const(2, 1, 16'h7FFF);
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    check("abort_keep_i", 64'(out_i), 64'h0FFF_0FFF);
    cyc(1, 0, 0, 0, 0, 0);
    run_const(6, 1, 16'h4000);
    check("reen_i", 64'(out_i), 64'h3FFF_3FFF);

    // Window length change mid-window applies from the next window.
    restart(16'd4);
    run_const(2, 1, 16'h4000);
    window_len = 16'd2;
    run_const(10, 1, 16'h4000);
    check("wchg_i", 64'(out_i), 64'h1FFF_1FFF);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) window_len = NW'($urandom_range(0, 5));
      cyc($urandom_range(0, 49) != 0, $urandom_range(0, 2) != 0,
          16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    end

    // Asynchronous reset mid-window.
    restart(16'd4);
    run_const(6, 1, 16'h4000);
    #3 rst = 1'b0;
    #1;
    check("arst_out_i", 64'(out_i), 64'd0);
    check("arst_out_q", 64'(out_q), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_ovf", 64'(ovf), 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    window_len = 16'd4;
    cyc(1, 0, 0, 0, 0, 0);
    run_const(6, 1, 16'h4000);
    check("post_rst_i", 64'(out_i), 64'h3FFF_3FFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
